regfile_mp: RTL and testbench

//  Parametrised multi-read-port integer register file for the core's decode/execute boundary.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_if.sv | 27 ++
 rtl/regfile_rd_port.sv | 53 +++++
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  // Clear sweep after reset, then normal operation.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  // Index width for a file of the given depth (never narrower than one bit).
  function automatic int rf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Write/read bus of the register file. The master drives addresses and data,
// the slave (the file itself) returns read data and the ready flag.
interface regfile_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  logic                           ready;
  logic                           wr_en;
  logic [ADDR_W-1:0]              wr_addr;
  logic [WIDTH-1:0]               wr_data;
  logic [NUM_RD-1:0]              rd_en;
  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0]   rd_data;

  modport master (
    input  ready, rd_data,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

  modport slave (
    output ready, rd_data,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One read port: index mux over the storage array, zero/range masking,
// same-cycle write bypass and an optional output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH         = RF_WIDTH,
  parameter int DEPTH         = RF_DEPTH,
  parameter int ADDR_W        = rf_addr_w(RF_DEPTH),
  parameter int RD_LATENCY    = 0,
  parameter int BYPASS        = 1,
  parameter int HARDWIRE_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [WIDTH-1:0]  i_regs [DEPTH],
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic             w_in_range;
  logic             w_zero_idx;
  logic             w_hit;
  logic [WIDTH-1:0] w_value;
  logic [WIDTH-1:0] r_rd_data;

  assign w_in_range = int'(i_rd_addr) < DEPTH;
  assign w_zero_idx = (HARDWIRE_ZERO != 0) && (i_rd_addr == '0);
  assign w_hit      = (BYPASS != 0) && i_wr_valid && (i_wr_addr == i_rd_addr);

  // Select the value this port would return for the current address.
  always_comb begin
    // NOTE: default assignment first so every path drives w_value and no latch is inferred.
    w_value = '0;
    if (i_run && i_rd_en && w_in_range && !w_zero_idx) begin
      if (w_hit) w_value = i_wr_data;
      else       w_value = i_regs[i_rd_addr];
    end
  end

  // Output register used when the read stage is pipelined.
  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= w_value;
  end

  assign o_rd_data = (RD_LATENCY == 0) ? w_value : r_rd_data;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a self-clearing reset
// sweep, write-to-read bypass and optional hardwired-zero entry.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH         = RF_WIDTH,
  parameter int DEPTH         = RF_DEPTH,
  parameter int NUM_RD        = 2,
  parameter int RD_LATENCY    = 0,
  parameter int BYPASS        = 1,
  parameter int HARDWIRE_ZERO = 1
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int ADDR_W = rf_addr_w(DEPTH);

  rf_state_t         r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_ready;
  logic [WIDTH-1:0]  r_regs [DEPTH];

  logic              w_run;
  logic              w_wr_valid;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [WIDTH-1:0]  w_mem_data;

  assign w_run = (r_state == RF_RUN);

  // A write lands only in RUN, in range, and not on the hardwired-zero entry;
  // anything presented while rst is high is discarded.
  assign w_wr_valid = !rst && w_run && bus.wr_en
                   && (int'(bus.wr_addr) < DEPTH)
                   && !((HARDWIRE_ZERO != 0) && (bus.wr_addr == '0));

  // The sweep and normal writes share one write port.
  assign w_mem_we   = !rst && (!w_run || w_wr_valid);
  assign w_mem_addr = w_run ? bus.wr_addr : r_clr_ptr;
  assign w_mem_data = w_run ? bus.wr_data : '0;

  // Clear sweep FSM: zero one entry per cycle, then enter RUN and raise ready.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
    if (rst) begin
      r_state   <= RF_CLEAR;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= RF_RUN;
            r_ready <= 1'b1;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        RF_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= RF_CLEAR;
        end
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; the sweep zeroes it so it can map onto plain RAM.
    if (w_mem_we) r_regs[w_mem_addr] <= w_mem_data;
  end

  assign bus.ready = r_ready;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .ADDR_W        (ADDR_W),
      .RD_LATENCY    (RD_LATENCY),
      .BYPASS        (BYPASS),
      .HARDWIRE_ZERO (HARDWIRE_ZERO)
    ) u_rd_port (
      .clk        (clk),
      .rst        (rst),
      .i_run      (w_run),
      .i_rd_en    (bus.rd_en[p]),
      .i_rd_addr  (bus.rd_addr[p]),
      .i_regs     (r_regs),
      .i_wr_valid (w_wr_valid),
      .i_wr_addr  (bus.wr_addr),
      .i_wr_data  (bus.wr_data),
      .o_rd_data  (bus.rd_data[p])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances cover the default file,
// a non-power-of-2 file without bypass, and a 3-port registered-read file.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int AW0 = rf_addr_w(32);
  localparam int AW1 = rf_addr_w(24);

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  regfile_if #(.WIDTH(32), .ADDR_W(AW0), .NUM_RD(2)) if0 ();
  regfile_if #(.WIDTH(32), .ADDR_W(AW1), .NUM_RD(2)) if1 ();
  regfile_if #(.WIDTH(32), .ADDR_W(AW0), .NUM_RD(3)) if2 ();

  regfile_mp u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  regfile_mp #(.DEPTH(24), .BYPASS(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  regfile_mp #(.NUM_RD(3), .RD_LATENCY(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starting at a negedge, sample ready on 40 negedges and count the low
  // samples; checks reads are masked mid-sweep and drops any pending write.
  task automatic sweep(input string tag);
    int c0 = 0;
    int c1 = 0;
    int c2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!if0.ready) c0++;
      if (!if1.ready) c1++;
      if (!if2.ready) c2++;
      if (i == 5) begin
        check({tag, "_clr_rd_dut0"}, if0.rd_data[0], 32'd0);
        check({tag, "_clr_rd_dut2"}, if2.rd_data[0], 32'd0);
      end
      if (i == 10) begin
        if0.wr_en = 1'b0;
        if1.wr_en = 1'b0;
        if2.wr_en = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_ready_low_dut0"}, 32'(c0), 32'd32);
    check({tag, "_ready_low_dut1"}, 32'(c1), 32'd24);
    check({tag, "_ready_low_dut2"}, 32'(c2), 32'd32);
  endtask

  initial begin
    rst = 1'b1;
    if0.wr_en = 1'b0; if0.wr_addr = '0; if0.wr_data = '0; if0.rd_en = '0; if0.rd_addr = '0;
    if1.wr_en = 1'b0; if1.wr_addr = '0; if1.wr_data = '0; if1.rd_en = '0; if1.rd_addr = '0;
    if2.wr_en = 1'b0; if2.wr_addr = '0; if2.wr_data = '0; if2.rd_en = '0; if2.rd_addr = '0;

    // 1/2: reset for 3 cycles, release with a write to x5 pending during the sweep.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_dut0", 32'(if0.ready), 32'd0);
    check("rst_ready_dut1", 32'(if1.ready), 32'd0);
    check("rst_rd_dut2", if2.rd_data[0], 32'd0);
    rst = 1'b0;
    if0.wr_en = 1'b1; if0.wr_addr = 5'd5; if0.wr_data = 32'hDEAD_BEEF;
    if1.wr_en = 1'b1; if1.wr_addr = 5'd5; if1.wr_data = 32'hDEAD_BEEF;
    if2.wr_en = 1'b1; if2.wr_addr = 5'd5; if2.wr_data = 32'hDEAD_BEEF;
    if0.rd_en = 2'b11; if0.rd_addr[0] = 5'd5;
    if2.rd_en = 3'b111; if2.rd_addr[0] = 5'd5;
    @(negedge clk);
    sweep("t1");

    for (int a = 1; a < 32; a++) begin
      if0.rd_addr[0] = 5'(a);
      if0.rd_addr[1] = 5'(31 - a + 1);
      #1;
      check($sformatf("t1_x%0d_p0", a), if0.rd_data[0], 32'd0);
      check($sformatf("t1_x%0d_p1", 32 - a), if0.rd_data[1], 32'd0);
    end
    @(negedge clk);
    if0.rd_addr[0] = 5'd5;
    if1.rd_en = 2'b11; if1.rd_addr[0] = 5'd5;
    #1;
    check("t2_x5_dut0", if0.rd_data[0], 32'd0);
    check("t2_x5_dut1", if1.rd_data[0], 32'd0);

    // 3: same-cycle write/read of x7, with and without bypass.
    @(negedge clk);
    if0.wr_en = 1'b1; if0.wr_addr = 5'd7; if0.wr_data = 32'h1234_5678;
    if0.rd_addr[0] = 5'd7; if0.rd_addr[1] = 5'd7;
    if1.wr_en = 1'b1; if1.wr_addr = 5'd7; if1.wr_data = 32'h1234_5678;
    if1.rd_addr[0] = 5'd7;
    #1;
    check("t3_bypass_p0", if0.rd_data[0], 32'h1234_5678);
    check("t3_bypass_p1", if0.rd_data[1], 32'h1234_5678);
    check("t3_nobypass_old", if1.rd_data[0], 32'd0);
    @(negedge clk);
    if0.wr_en = 1'b0;
    if1.wr_en = 1'b0;
    #1;
    check("t3_bypass_stored", if0.rd_data[0], 32'h1234_5678);
    check("t3_nobypass_new", if1.rd_data[0], 32'h1234_5678);

    // 4: hardwired zero on dut0; out-of-range write on the 24-entry dut1.
    @(negedge clk);
    if0.wr_en = 1'b1; if0.wr_addr = 5'd1; if0.wr_data = 32'hAAAA_5555;
    if1.wr_en = 1'b1; if1.wr_addr = 5'd28; if1.wr_data = 32'h5A5A_5A5A;
    if1.rd_addr[0] = 5'd28;
    #1;
    check("t4_oor_same_cycle", if1.rd_data[0], 32'd0);
    @(negedge clk);
    if0.wr_addr = 5'd0; if0.wr_data = 32'hFFFF_FFFF;
    if0.rd_addr[0] = 5'd0; if0.rd_addr[1] = 5'd0;
    if1.wr_en = 1'b0;
    #1;
    check("t4_x0_same_cycle_p0", if0.rd_data[0], 32'd0);
    check("t4_x0_same_cycle_p1", if0.rd_data[1], 32'd0);
    check("t4_oor_after", if1.rd_data[0], 32'd0);
    @(negedge clk);
    if0.wr_en = 1'b0;
    #1;
    check("t4_x0_p0", if0.rd_data[0], 32'd0);
    check("t4_x0_p1", if0.rd_data[1], 32'd0);
    if0.rd_addr[1] = 5'd1;
    #1;
    check("t4_x1_kept", if0.rd_data[1], 32'hAAAA_5555);

    // 5: registered reads on the 3-port file.
    @(negedge clk);
    if2.wr_en = 1'b1; if2.wr_addr = 5'd3; if2.wr_data = 32'hA1A1_A1A1;
    @(negedge clk);
    if2.wr_addr = 5'd4; if2.wr_data = 32'hB2B2_B2B2;
    @(negedge clk);
    if2.wr_addr = 5'd9; if2.wr_data = 32'hC3C3_C3C3;
    @(negedge clk);
    if2.wr_en = 1'b0;
    if2.rd_en = 3'b101;
    if2.rd_addr[0] = 5'd3; if2.rd_addr[1] = 5'd4; if2.rd_addr[2] = 5'd9;
    #1;
    check("t5_before_edge_p0", if2.rd_data[0], 32'd0);
    @(negedge clk);
    check("t5_p0", if2.rd_data[0], 32'hA1A1_A1A1);
    check("t5_p1", if2.rd_data[1], 32'd0);
    check("t5_p2", if2.rd_data[2], 32'hC3C3_C3C3);
    if2.wr_en = 1'b1; if2.wr_addr = 5'd10; if2.wr_data = 32'hD4D4_D4D4;
    if2.rd_en = 3'b010; if2.rd_addr[1] = 5'd10;
    @(negedge clk);
    if2.wr_en = 1'b0;
    check("t5_reg_bypass_p1", if2.rd_data[1], 32'hD4D4_D4D4);
    check("t5_disabled_p0", if2.rd_data[0], 32'd0);
    if2.rd_en = 3'b001; if2.rd_addr[0] = 5'd3;

    // 6: mid-run reset with a write pending.
    for (int a = 1; a <= 4; a++) begin
      @(negedge clk);
      if0.wr_en = 1'b1; if0.wr_addr = 5'(a); if0.wr_data = 32'h0000_0100 + 32'(a);
    end
    @(negedge clk);
    if0.wr_en = 1'b0;
    if0.rd_addr[0] = 5'd3;
    #1;
    check("t6_loaded_x3", if0.rd_data[0], 32'h0000_0103);
    @(negedge clk);
    rst = 1'b1;
    if0.wr_en = 1'b1; if0.wr_addr = 5'd6; if0.wr_data = 32'hCAFE_F00D;
    #1;
    check("t6_ready_before", 32'(if0.ready), 32'd1);
    check("t6_dut2_rd_before", if2.rd_data[0], 32'hA1A1_A1A1);
    @(negedge clk);
    rst = 1'b0;
    if0.wr_en = 1'b0;
    check("t6_ready_dropped", 32'(if0.ready), 32'd0);
    check("t6_dut2_rd_reset", if2.rd_data[0], 32'd0);
    sweep("t6");
    if0.rd_en = 2'b11;
    for (int a = 1; a <= 6; a++) begin
      if0.rd_addr[0] = 5'(a);
      #1;
      check($sformatf("t6_x%0d_cleared", a), if0.rd_data[0], 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
